// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer types, size/response encodings and the
// responder state enum used by AHB slaves in this codebase.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slave_state_t;

endpackage

// File: rtl/ahb_byte_lane_decode.sv
// Maps an AHB transfer size and low address bits to a little-endian byte-lane
// enable mask and flags misaligned or oversized transfers (mask is zero then).
module ahb_byte_lane_decode
    import ahb_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr,
    output logic [3:0] lanes,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        lanes   = 4'b0000;
        illegal = 1'b0;
        case (size)
            HSIZE_BYTE: lanes = 4'b0001 << addr;
            HSIZE_HALF: begin
                illegal = addr[0];
                lanes   = addr[1] ? 4'b1100 : 4'b0011;
            end
            HSIZE_WORD: begin
                illegal = (addr != 2'b00);
                lanes   = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) lanes = 4'b0000;
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-organised SRAM responder with configurable wait states and a
// two-cycle ERROR response. Define AHB_SRAM_HPROT_CHECK_EN to reject unprivileged writes.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int AWIDTH      = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DWIDTH-1:0] HWDATA,
    input  logic              HREADY,
`ifdef AHB_SRAM_HPROT_CHECK_EN
    input  logic [3:0]        HPROT,
`endif
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DWIDTH-1:0] HRDATA
);

    localparam int         DEPTH = 2 ** (AWIDTH - 2);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    htrans_t           trans;
    slave_state_t      state_q, state_d;
    logic [3:0]        cnt_q;
    logic              valid_q, write_q;
    logic [AWIDTH-3:0] widx_q;
    logic [3:0]        lanes_q;
    logic [3:0]        lanes;
    logic              size_illegal, illegal;
    logic              ready, take, complete;
    logic              unused_bits;
    logic [DWIDTH-1:0] mem [DEPTH];

    assign trans = htrans_t'(HTRANS);

    ahb_byte_lane_decode u_lane_decode (
        .size    (HSIZE),
        .addr    (HADDR[1:0]),
        .lanes   (lanes),
        .illegal (size_illegal)
    );

`ifdef AHB_SRAM_HPROT_CHECK_EN
    assign illegal     = size_illegal | (HWRITE & ~HPROT[1]);
    assign unused_bits = &{1'b0, HADDR[31:AWIDTH], HPROT[3:2], HPROT[0]};
`else
    assign illegal     = size_illegal;
    assign unused_bits = &{1'b0, HADDR[31:AWIDTH]};
`endif

    // A new address phase is only taken while this slave is not stalling or erroring.
    assign ready    = (state_q == ST_IDLE) || (state_q == ST_WAIT && cnt_q == 4'd0);
    assign take     = ready && HSEL && HREADY && (trans == NONSEQ || trans == SEQ);
    assign complete = valid_q && ready;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (ready) begin
                    if (take)
                        state_d = illegal ? ST_ERR1 : ((WAIT_STATES > 0) ? ST_WAIT : ST_IDLE);
                    else
                        state_d = ST_IDLE;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            ST_WAIT: HREADYOUT = (cnt_q == 4'd0);
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            widx_q  <= '0;
            lanes_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (ready) begin
                valid_q <= take && !illegal;
                if (take) begin
                    write_q <= HWRITE;
                    widx_q  <= HADDR[AWIDTH-1:2];
                    lanes_q <= lanes;
                end
            end
            if (take && !illegal)  cnt_q <= WS;
            else if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
    end

    // NOTE: the RAM array is deliberately not reset; only control flops see HRESET.
    always_ff @(posedge HCLK) begin
        if (complete && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes_q[b]) mem[widx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HRDATA = (complete && !write_q) ? mem[widx_q] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: a zero-wait and a three-wait instance
// share one bus; a scoreboard queue holds the expected response of each transfer.
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    typedef struct {
        logic        resp;
        logic [31:0] data;
        int          low;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel, hwrite, force_low, tgt;
    logic [31:0] haddr, hwdata, pend_wdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hsel0, hsel3, hready;
    logic        ro0, ro3, rsp0, rsp3, ro, rsp;
    logic [31:0] rd0, rd3, rd;
`ifdef AHB_SRAM_HPROT_CHECK_EN
    logic [3:0]  hprot;
`endif

    exp_t        sb[$];
    logic [31:0] model [2][1024];
    int          total = 0;
    int          bad   = 0;
    int          lowc  = 0;
    logic        dphase;

    always #5 clk = ~clk;

    assign hsel0  = hsel & ~tgt;
    assign hsel3  = hsel & tgt;
    assign ro     = tgt ? ro3 : ro0;
    assign rsp    = tgt ? rsp3 : rsp0;
    assign rd     = tgt ? rd3 : rd0;
    assign hready = force_low ? 1'b0 : ro;

    ahb_sram_slave #(.DWIDTH(32), .AWIDTH(12), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
`ifdef AHB_SRAM_HPROT_CHECK_EN
        .HPROT(hprot),
`endif
        .HREADYOUT(ro0), .HRESP(rsp0), .HRDATA(rd0)
    );

    ahb_sram_slave #(.DWIDTH(32), .AWIDTH(12), .WAIT_STATES(3)) dut3 (
        .HCLK(clk), .HRESET(rst), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
`ifdef AHB_SRAM_HPROT_CHECK_EN
        .HPROT(hprot),
`endif
        .HREADYOUT(ro3), .HRESP(rsp3), .HRDATA(rd3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one address phase (plus the previous transfer's write data), record
    // the expected outcome, and return after the edge that accepts it.
    task automatic issue(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd);
        exp_t       e;
        logic       ill;
        logic [3:0] m;
        logic       got;
        hsel   = 1'b1;
        htrans = tr;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        hwdata = pend_wdata;
        if (tr[1]) begin
            ill = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
`ifdef AHB_SRAM_HPROT_CHECK_EN
            ill = ill || (wr && !hprot[1]);
`endif
            e.resp = ill;
            e.low  = ill ? 1 : (tgt ? 3 : 0);
            e.data = 32'd0;
            if (!ill) begin
                if (wr) begin
                    case (sz)
                        3'd0:    m = 4'b0001 << a[1:0];
                        3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
                        default: m = 4'b1111;
                    endcase
                    for (int l = 0; l < 4; l++)
                        if (m[l]) model[tgt][a[11:2]][8*l +: 8] = wd[8*l +: 8];
                end else begin
                    e.data = model[tgt][a[11:2]];
                end
            end
            sb.push_back(e);
        end
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = hready;
            @(posedge clk);
        end
        check("accept_timeout", 32'(got), 32'd1);
        #1;
        pend_wdata = wd;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst)         dphase <= 1'b0;
        else if (hready) dphase <= hsel && htrans[1];
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && dphase) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb[0];
                if (!ro) begin
                    lowc++;
                    check("wait_hresp", 32'(rsp), 32'(e.resp));
                    check("wait_hrdata", rd, 32'd0);
                end else begin
                    check("hresp", 32'(rsp), 32'(e.resp));
                    check("hrdata", rd, e.data);
                    check("wait_cycles", lowc, e.low);
                    lowc = 0;
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b1; hsel = 1'b0; htrans = IDLE; hwrite = 1'b0; haddr = '0;
        hsize = HSIZE_WORD; hwdata = '0; pend_wdata = '0; force_low = 1'b0; tgt = 1'b0;
`ifdef AHB_SRAM_HPROT_CHECK_EN
        hprot = 4'b0011;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_hreadyout0", 32'(ro0), 32'd1);
        check("rst_hresp0", 32'(rsp0), 32'd0);
        check("rst_hrdata0", rd0, 32'd0);
        check("rst_hreadyout3", 32'(ro3), 32'd1);
        check("rst_hresp3", 32'(rsp3), 32'd0);
        check("rst_hrdata3", rd3, 32'd0);
        rst = 1'b0;

        // Zero wait states: write then back-to-back read, byte/halfword merges, aliasing.
        issue(NONSEQ, 1'b1, 32'h010, HSIZE_WORD, 32'hDEADBEEF);
        issue(NONSEQ, 1'b0, 32'h010, HSIZE_WORD, 32'h0);
        issue(NONSEQ, 1'b1, 32'h010, HSIZE_WORD, 32'h11223344);
        issue(SEQ,    1'b1, 32'h013, HSIZE_BYTE, 32'hAA000000);
        issue(NONSEQ, 1'b0, 32'h010, HSIZE_WORD, 32'h0);
        issue(NONSEQ, 1'b1, 32'h012, HSIZE_HALF, 32'h55660000);
        issue(NONSEQ, 1'b0, 32'h010, HSIZE_BYTE, 32'h0);
        issue(NONSEQ, 1'b0, 32'h1010, HSIZE_WORD, 32'h0);
        issue(IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h0);

        // Illegal transfers: unaligned word write, misaligned half read, oversize.
        issue(NONSEQ, 1'b1, 32'h000, HSIZE_WORD, 32'h0BADF00D);
        issue(IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h0);
        issue(NONSEQ, 1'b1, 32'h002, HSIZE_WORD, 32'h11111111);
        issue(IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h0);
        issue(NONSEQ, 1'b0, 32'h011, HSIZE_HALF, 32'h0);
        issue(IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h0);
        issue(NONSEQ, 1'b1, 32'h000, 3'd3, 32'h22222222);
        issue(IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h0);
        issue(NONSEQ, 1'b0, 32'h000, HSIZE_WORD, 32'h0);
        issue(IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h0);

        // IDLE/BUSY with HSEL high and NONSEQ with HREADY low: no capture.
        hsel = 1'b1; htrans = IDLE; hwrite = 1'b1; haddr = 32'h010; hsize = HSIZE_WORD;
        hwdata = 32'hFFFFFFFF;
        @(negedge clk);
        check("idle_hreadyout", 32'(ro), 32'd1);
        check("idle_hresp", 32'(rsp), 32'd0);
        @(posedge clk); #1;
        htrans = BUSY;
        @(negedge clk);
        check("busy_hreadyout", 32'(ro), 32'd1);
        check("busy_hresp", 32'(rsp), 32'd0);
        @(posedge clk); #1;
        htrans = NONSEQ; force_low = 1'b1;
        @(negedge clk);
        check("nordy_hreadyout", 32'(ro), 32'd1);
        check("nordy_hresp", 32'(rsp), 32'd0);
        @(posedge clk); #1;
        htrans = IDLE; force_low = 1'b0;
        @(posedge clk); #1;
        issue(NONSEQ, 1'b0, 32'h010, HSIZE_WORD, 32'h0);
        issue(IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h0);

        // Three wait states: write and back-to-back read.
        tgt = 1'b1;
        issue(NONSEQ, 1'b1, 32'h040, HSIZE_WORD, 32'hCAFEF00D);
        issue(NONSEQ, 1'b0, 32'h040, HSIZE_WORD, 32'h0);
        issue(NONSEQ, 1'b1, 32'h020, HSIZE_WORD, 32'h12345678);
        issue(IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h0);

        // Reset pulse in the second wait cycle of a write: write is discarded.
        hsel = 1'b1; htrans = NONSEQ; hwrite = 1'b1; haddr = 32'h020; hsize = HSIZE_WORD;
        sb.push_back('{resp: 1'b0, data: 32'd0, low: 3});
        @(posedge clk); #1;
        htrans = IDLE; hwdata = 32'hBAD0BAD0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_hreadyout", 32'(ro3), 32'd1);
        check("abort_hresp", 32'(rsp3), 32'd0);
        check("abort_hrdata", rd3, 32'd0);
        sb.delete();
        lowc = 0;
        pend_wdata = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(NONSEQ, 1'b0, 32'h020, HSIZE_WORD, 32'h0);
        issue(IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h0);

`ifdef AHB_SRAM_HPROT_CHECK_EN
        // Unprivileged write is rejected with ERROR and leaves the RAM untouched.
        tgt = 1'b0;
        hprot = 4'b0001;
        issue(NONSEQ, 1'b1, 32'h010, HSIZE_WORD, 32'h99999999);
        issue(IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h0);
        hprot = 4'b0011;
        issue(NONSEQ, 1'b0, 32'h010, HSIZE_WORD, 32'h0);
        issue(IDLE,   1'b0, 32'h0, HSIZE_WORD, 32'h0);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
